// File: rtl/acc_drain_pkg.sv
// Shared types and defaults for the accumulator-buffer drain path.
// Holds the drain FSM states and the pair-readiness check against the writer count.
package acc_drain_pkg;

  localparam int NCH_DEF    = 4;
  localparam int AW_DEF     = 12;
  localparam int DW_DEF     = 32;
  localparam int RD_LAT_DEF = 2;

  typedef enum logic [2:0] {
    IDLE,
    RDX,
    RDY,
    WAIT,
    HOLD
  } state_t;

  // A pair is ready only when both x and y sit below the writer count.
  // A writer count behind the read pointer therefore never reports pending.
  function automatic logic pair_pending(input logic [31:0] wr, input logic [31:0] rp);
    return wr >= rp + 32'd2;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin request picker: purpose, pick the first requester at or after the priority pointer.
// Latency: grant/any are combinational from req; pointer update takes effect the next cycle.
// Backpressure: none; the pointer only moves on advance and returns to 0 on clear.
module rr_arbiter #(
  parameter int N = 4,
  localparam int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic [N-1:0]  req,
  input  logic          advance,
  input  logic          clear,
  output logic [IW-1:0] grant,
  output logic          any
);

  logic [IW-1:0] ptr;

  always_comb begin
    int idx;
    idx   = 0;
    grant = '0;
    any   = 1'b0;
    // Walk from the far end back towards ptr so the nearest requester wins.
    for (int k = N - 1; k >= 0; k--) begin
      idx = (int'(ptr) + k) % N;
      if (req[idx]) begin
        grant = IW'(idx);
        any   = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ptr <= '0;
    end else if (clear) begin
      ptr <= '0;
    end else if (advance) begin
      ptr <= IW'((int'(grant) + 1) % N);
    end
  end

endmodule

// File: rtl/acc_drain.sv
// Drains completed (x, y) pairs from the per-channel accumulator RAMs into a valid/ready stream.
// Latency: pending in IDLE at c gives out_valid at c+3+RD_LAT; one pair per RD_LAT+4 cycles peak.
// Backpressure: holds the pair stable and issues no reads until out_ready; start aborts everything.
module acc_drain
  import acc_drain_pkg::*;
#(
  parameter int NCH    = NCH_DEF,
  parameter int AW     = AW_DEF,
  parameter int DW     = DW_DEF,
  parameter int RD_LAT = RD_LAT_DEF
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic                      start,
  input  logic [NCH*(AW+1)-1:0]     wr_ptr,
  output logic                      rd_en,
  output logic [AW-1:0]             rd_addr,
  output logic [$clog2(NCH)-1:0]    rd_sel,
  input  logic [NCH*DW-1:0]         rd_data,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [2*DW-1:0]           out_data,
  output logic [$clog2(NCH)-1:0]    out_chan,
  output logic [AW-2:0]             out_index,
  output logic [NCH-1:0]            overrun,
  output logic                      busy
);

  localparam int CW = $clog2(NCH);
  localparam int PW = AW + 1;

  state_t          state, state_n;
  logic [CW-1:0]   gnt_q;
  logic [CW-1:0]   arb_gnt;
  logic            arb_any;
  logic            arb_adv;
  logic [AW:0]     rp [NCH];
  logic [NCH-1:0]  pend;
  logic [NCH-1:0]  ovr_now;
  logic [1:0]      tag_q [RD_LAT];  // {vld, is_y}
  logic            rd_is_y_q;
  logic [DW-1:0]   x_q;
  logic [DW-1:0]   sel_dat;
  logic            cap_x, cap_y;
  logic            hs;

  always_comb begin
    pend    = '0;
    ovr_now = '0;
    for (int i = 0; i < NCH; i++) begin
      ovr_now[i] = wr_ptr[i*PW +: PW] < rp[i];
      pend[i]    = pair_pending(32'(wr_ptr[i*PW +: PW]), 32'(rp[i]));
    end
  end

  assign arb_adv = (state == IDLE) && arb_any && !start;

  rr_arbiter #(.N(NCH)) u_arb (
    .clk     (clk),
    .reset_n (reset_n),
    .req     (pend),
    .advance (arb_adv),
    .clear   (start),
    .grant   (arb_gnt),
    .any     (arb_any)
  );

  assign sel_dat = rd_data[gnt_q*DW +: DW];
  assign cap_x   = tag_q[RD_LAT-1][1] && !tag_q[RD_LAT-1][0];
  assign cap_y   = tag_q[RD_LAT-1][1] &&  tag_q[RD_LAT-1][0];
  assign hs      = (state == HOLD) && out_ready && !start;

  always_comb begin
    state_n = state;
    case (state)
      IDLE:    if (arb_any) state_n = RDX;
      RDX:     state_n = RDY;
      RDY:     state_n = WAIT;
      WAIT:    if (cap_y) state_n = HOLD;
      HOLD:    if (out_ready) state_n = IDLE;
      default: state_n = IDLE;
    endcase
    if (start) state_n = IDLE;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      busy      <= 1'b0;
      gnt_q     <= '0;
      rd_en     <= 1'b0;
      rd_is_y_q <= 1'b0;
      rd_addr   <= '0;
      rd_sel    <= '0;
      x_q       <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_chan  <= '0;
      out_index <= '0;
      overrun   <= '0;
      for (int i = 0; i < NCH; i++) rp[i] <= '0;
      for (int k = 0; k < RD_LAT; k++) tag_q[k] <= '0;
    end else begin
      state     <= state_n;
      busy      <= (state_n != IDLE);
      rd_en     <= (state_n == RDX) || (state_n == RDY);
      rd_is_y_q <= (state_n == RDY);
      out_valid <= (state_n == HOLD);

      if (arb_adv) begin
        gnt_q   <= arb_gnt;
        rd_sel  <= arb_gnt;
        rd_addr <= rp[arb_gnt][AW-1:0];
      end else if (state == RDX) begin
        rd_addr <= rp[gnt_q][AW-1:0] + AW'(1);
      end

      // Tags follow each read through the RAM latency; start wipes them so late data is ignored.
      tag_q[0] <= start ? 2'b00 : {rd_en, rd_is_y_q};
      for (int k = 1; k < RD_LAT; k++) tag_q[k] <= start ? 2'b00 : tag_q[k-1];

      if (cap_x) x_q <= sel_dat;
      if (cap_y && (state == WAIT) && !start) begin
        out_data  <= {sel_dat, x_q};
        out_chan  <= gnt_q;
        out_index <= rp[gnt_q][AW-1:1];
      end

      if (start) begin
        for (int i = 0; i < NCH; i++) rp[i] <= '0;
        overrun <= '0;
      end else begin
        if (hs) rp[gnt_q] <= rp[gnt_q] + PW'(2);
        overrun <= overrun | ovr_now;
      end
    end
  end

endmodule

// File: doc/acc_drain.md
# acc_drain

Reader side of the per-measurement accumulator buffers. The writer pushes one (x, y) 32-bit pair per measurement into a dual-port RAM at consecutive even/odd addresses and publishes its word count (`accaddr`, bit AW = full). acc_drain follows those counts, reads completed pairs through the RAM's DSP-clock read port and emits them as a valid/ready stream tagged with channel and pair index. It feeds a DMA or streaming path, replacing host polling of the buffers over the local bus.

## Interface
Parameters:
- `NCH`, 4: number of measurement channels.
- `AW`, 12: RAM address width; a channel holds at most 2^AW words.
- `DW`, 32: data word width.
- `RD_LAT`, 2: cycles from `rd_en` high to valid `rd_data`; legal range 1..4.

Ports:
- `clk`  in  1  DSP clock; the block's only clock.
- `reset_n`  in  1  reset; asynchronous, active-low.
- `start`  in  1  one-cycle pulse; clears all read pointers; must coincide with the writer's `stb_start`.
- `wr_ptr`  in  NCH*(AW+1)  per-channel writer word count, channel i at bits [i*(AW+1) +: AW+1].
- `rd_en`  out  1  read strobe to the RAM port.
- `rd_addr`  out  AW  read address.
- `rd_sel`  out  $clog2(NCH)  channel being read.
- `rd_data`  in  NCH*DW  read data from all channels; the block selects the channel internally.
- `out_valid`  out  1  output pair available.
- `out_ready`  in  1  consumer accepts.
- `out_data`  out  2*DW  {y, x}.
- `out_chan`  out  $clog2(NCH)  source channel.
- `out_index`  out  AW-1  pair index within the channel (read pointer / 2).
- `overrun`  out  NCH  sticky per channel; set when `wr_ptr < rp`.
- `busy`  out  1  state is not IDLE.

## Operation
- Per channel, read pointer `rp[i]` is AW+1 bits, reset 0, and always even.
- `pending[i] = (wr_ptr[i] >= rp[i] + 2)`. An odd trailing word (y not yet written) is not pending.
- A channel stops being pending once `rp[i] == 2^AW`, which matches the writer's full stop. The pointer never wraps.
- `overrun[i]` sets when `wr_ptr[i] < rp[i]`; `pending[i]` is forced 0 while that holds. Cleared only by `start` or reset.
- Arbitration is round-robin over pending channels. The search starts at last grant + 1; after reset and after `start` it starts at channel 0.
- States:
  - IDLE: if any channel is pending, latch the grant and go to RDX.
  - RDX: `rd_en`=1, `rd_addr`=rp, go to RDY.
  - RDY: `rd_en`=1, `rd_addr`=rp+1, go to WAIT.
  - WAIT: capture x and y as they arrive; after y is captured, go to HOLD.
  - HOLD: `out_valid`=1. On `out_ready`: rp[grant] += 2, go to IDLE.
- `out_data`, `out_chan` and `out_index` stay stable while `out_valid & ~out_ready`.
- `start` has priority in every state:
  - state goes to IDLE and `out_valid` drops the next cycle;
  - all rp are cleared and all `overrun` bits are cleared;
  - read data still in flight is discarded through an internal per-slot valid pipeline, never captured.
- Reset values: every output 0, all rp 0, state IDLE.

## Timing
- Every output is registered; there is no combinational path from input to output.
- Channel pending in IDLE at cycle c:
  - `rd_en`/`rd_addr`=x at c+1, y at c+2.
  - x is sampled at c+1+RD_LAT, y at c+2+RD_LAT.
  - `out_valid` is high from c+3+RD_LAT. With RD_LAT=2 that is c+5.
- Handshake at cycle h (`out_valid & out_ready`): the rp update is visible at h+1, state is IDLE at h+1, and the next `rd_en` is at h+2 at the earliest.
- Peak rate with `out_ready` held high is one pair per RD_LAT+4 cycles.
- `wr_ptr` is sampled combinationally in IDLE only. The writer's count may advance at any time, and an increment is picked up on the next IDLE evaluation.
- `out_ready` high while `out_valid` is low has no effect.

## Structure
- Package `acc_drain_pkg`: state enum (IDLE, RDX, RDY, WAIT, HOLD), default NCH/AW/DW/RD_LAT localparams, and a function `pair_pending(wr, rp)`.
- Sub-module `rr_arbiter` (parameter N): inputs `req[N]`, `advance`, `clear`; output `grant` index plus `any`. The priority pointer moves only on `advance` and returns to 0 on `clear`.
- Read-latency alignment uses an RD_LAT-deep shift register of {valid, is_y} tags inside acc_drain.

## Test plan
- Single pair: ch0 `wr_ptr`=2, RAM x=0x11111111, y=0x22222222, `out_ready`=1 → `out_valid` at c+5, `out_data`=0x22222222_11111111, `out_chan`=0, `out_index`=0, then rp0=2 and `busy` falls.
- Round-robin: ch1 and ch3 each `wr_ptr`=4 → output order ch1 idx0, ch3 idx0, ch1 idx1, ch3 idx1.
- Backpressure: `out_ready`=0 for 20 cycles in HOLD → `out_data` unchanged and no `rd_en`; one-cycle `out_ready` → exactly one acceptance.
- Odd and full counts: `wr_ptr`=3 → one pair only; `wr_ptr`=4096 → 2048 pairs, last `out_index`=2047, then idle.
- `start` mid-read (asserted in WAIT) → no `out_valid`, in-flight data dropped, rp all 0, a fresh pair is read correctly afterwards.
- Overrun: rp0=6 and `wr_ptr` drops to 2 without `start` → `overrun[0]`=1, no reads from ch0; `start` clears it.
